// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 bus definitions for the LCD read and write controllers.
package lcd_pkg;

    localparam int LCD_BF_BIT = 7;

    typedef enum logic {
        LCD_RD_BF_AC = 1'b0,
        LCD_RD_DATA  = 1'b1
    } lcd_rd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_rd_st_e;

    function automatic int ns_to_cyc(input int ns, input int period_ns);
        return (ns + period_ns - 1) / period_ns;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter; o_done is high while the count sits at zero.
module lcd_phase_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = i_load ? i_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_done = cnt_q == '0;

endmodule

// File: rtl/lcd_rd_ctrl.sv
// lcd_rd_ctrl: HD44780 read-cycle engine returning busy flag/AC or a data byte.
// LCD_RD_BUSY_POLL_EN adds i_poll/o_timeout: repeat BF/AC reads until the busy flag clears.
module lcd_rd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PERIOD_NS = 40,
    parameter int T_AS_NS     = 80,
    parameter int T_PW_NS     = 460,
    parameter int T_DDR_NS    = 320,
    parameter int T_CYCE_NS   = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vld,
    output logic       o_rdy,
    input  logic       i_rs,
`ifdef LCD_RD_BUSY_POLL_EN
    input  logic       i_poll,
    output logic       o_timeout,
`endif
    output logic       o_rd_vld,
    output logic [7:0] o_rd_data,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic       o_bus_rd,
    output logic       o_LCD_RW,
    output logic       o_LCD_RS,
    output logic       o_LCD_EN,
    input  logic [7:0] i_LCD_DATA
);

    localparam int AS_CYC  = ns_to_cyc(T_AS_NS, T_PERIOD_NS);
    localparam int PW_CYC  = ns_to_cyc(T_PW_NS, T_PERIOD_NS);
    localparam int DDR_CYC = ns_to_cyc(T_DDR_NS, T_PERIOD_NS);
    localparam int CYC_CYC = ns_to_cyc(T_CYCE_NS, T_PERIOD_NS);
    localparam int HD_RAW  = CYC_CYC - AS_CYC - PW_CYC;
    localparam int HD_CYC  = HD_RAW < 1 ? 1 : HD_RAW;
    localparam int MX1     = AS_CYC > PW_CYC ? AS_CYC : PW_CYC;
    localparam int MX      = MX1 > HD_CYC ? MX1 : HD_CYC;
    localparam int TW      = $clog2(MX + 1);
    localparam logic [TW-1:0] AS_LD = TW'(AS_CYC - 1);
    localparam logic [TW-1:0] PW_LD = TW'(PW_CYC - 1);
    localparam logic [TW-1:0] HD_LD = TW'(HD_CYC - 1);

    // The capture uses the registered copy of LCD_DATA, so data must settle one cycle before EN falls.
    if (DDR_CYC + 1 > PW_CYC) begin : g_ddr_chk
        $error("lcd_rd_ctrl: DDR_CYC+1 exceeds PW_CYC, read data would be captured before it is valid");
    end

    lcd_rd_st_e st_q, st_d;
    lcd_rd_e    rs_q, rs_d;
    logic       rdy_q, rdy_d, rd_vld_q, rd_vld_d, bus_q, bus_d, en_q, en_d, busy_q, busy_d;
    logic [7:0] din_q, din_d, cap_q, cap_d, rd_data_q, rd_data_d;
    logic [6:0] ac_q, ac_d;
    logic       tmr_load, tmr_done, accept, hold_end, repeat_rd, poll_req;
    logic [TW-1:0] tmr_val;

    assign accept   = st_q == ST_IDLE && i_vld;
    assign hold_end = st_q == ST_HOLD && tmr_done;

    lcd_phase_timer #(.W(TW)) u_tmr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (tmr_load),
        .i_val   (tmr_val),
        .o_done  (tmr_done)
    );

`ifdef LCD_RD_BUSY_POLL_EN
    logic        poll_q, poll_d, to_q, to_d;
    logic [15:0] pcnt_q, pcnt_d;
    assign poll_req  = i_poll;
    assign repeat_rd = poll_q && cap_q[LCD_BF_BIT] && pcnt_q != 16'hFFFE;
    always_comb begin
        poll_d = accept ? i_poll : poll_q;
        pcnt_d = accept ? 16'd0 : (hold_end && repeat_rd ? pcnt_q + 16'd1 : pcnt_q);
        to_d   = accept ? 1'b0 : (hold_end ? !repeat_rd && poll_q && cap_q[LCD_BF_BIT] : to_q);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            poll_q <= 1'b0;
            pcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            poll_q <= poll_d;
            pcnt_q <= pcnt_d;
            to_q   <= to_d;
        end
    end
    assign o_timeout = to_q;
`else
    assign poll_req  = 1'b0;
    assign repeat_rd = 1'b0;
`endif

    always_comb begin
        st_d      = st_q;
        rs_d      = rs_q;
        rdy_d     = rdy_q;
        bus_d     = bus_q;
        en_d      = en_q;
        busy_d    = busy_q;
        ac_d      = ac_q;
        cap_d     = cap_q;
        rd_data_d = rd_data_q;
        din_d     = i_LCD_DATA;
        rd_vld_d  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = AS_LD;
        unique case (st_q)
            ST_IDLE: if (i_vld) begin
                st_d     = ST_SETUP;
                rs_d     = poll_req ? LCD_RD_BF_AC : lcd_rd_e'(i_rs);
                rdy_d    = 1'b0;
                bus_d    = 1'b1;
                tmr_load = 1'b1;
            end
            ST_SETUP: if (tmr_done) begin
                st_d     = ST_PULSE;
                en_d     = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = PW_LD;
            end
            ST_PULSE: if (tmr_done) begin
                st_d     = ST_HOLD;
                en_d     = 1'b0;
                cap_d    = din_q;
                tmr_load = 1'b1;
                tmr_val  = HD_LD;
            end
            ST_HOLD: if (tmr_done) begin
                tmr_load = repeat_rd;
                if (!repeat_rd) begin
                    st_d      = ST_IDLE;
                    rs_d      = LCD_RD_BF_AC;
                    rdy_d     = 1'b1;
                    bus_d     = 1'b0;
                    rd_vld_d  = 1'b1;
                    rd_data_d = cap_q;
                    busy_d    = rs_q == LCD_RD_BF_AC ? cap_q[LCD_BF_BIT] : busy_q;
                    ac_d      = rs_q == LCD_RD_BF_AC ? cap_q[6:0] : ac_q;
                end else begin
                    st_d = ST_SETUP;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            st_q      <= ST_IDLE;
            rs_q      <= LCD_RD_BF_AC;
            rdy_q     <= 1'b1;
            bus_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            ac_q      <= '0;
            cap_q     <= '0;
            rd_data_q <= '0;
            din_q     <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            st_q      <= st_d;
            rs_q      <= rs_d;
            rdy_q     <= rdy_d;
            bus_q     <= bus_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            ac_q      <= ac_d;
            cap_q     <= cap_d;
            rd_data_q <= rd_data_d;
            din_q     <= din_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign o_rdy     = rdy_q;
    assign o_rd_vld  = rd_vld_q;
    assign o_rd_data = rd_data_q;
    assign o_busy    = busy_q;
    assign o_ac      = ac_q;
    assign o_bus_rd  = bus_q;
    assign o_LCD_RW  = bus_q;
    assign o_LCD_RS  = rs_q;
    assign o_LCD_EN  = en_q;

endmodule

// File: tb/tb_lcd_rd_ctrl.sv
// tb_lcd_rd_ctrl: directed vector bench for lcd_rd_ctrl with a small HD44780 read-side bus model.
module tb_lcd_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, vld, rs;
    logic       rdy, rd_vld, busy, bus_rd, lcd_rw, lcd_rs, lcd_en;
    logic [7:0] rd_data, lcd_data, model_val;
    logic [6:0] ac;
    int         en_age;
    int         n_pass = 0, n_tot = 0;
`ifdef LCD_RD_BUSY_POLL_EN
    logic       poll, timeout;
`endif

    always #5 clk = ~clk;

    lcd_rd_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_vld      (vld),
        .o_rdy      (rdy),
        .i_rs       (rs),
`ifdef LCD_RD_BUSY_POLL_EN
        .i_poll     (poll),
        .o_timeout  (timeout),
`endif
        .o_rd_vld   (rd_vld),
        .o_rd_data  (rd_data),
        .o_busy     (busy),
        .o_ac       (ac),
        .o_bus_rd   (bus_rd),
        .o_LCD_RW   (lcd_rw),
        .o_LCD_RS   (lcd_rs),
        .o_LCD_EN   (lcd_en),
        .i_LCD_DATA (lcd_data)
    );

    // LCD model: bus reads 0xFF until 8 clocks after EN rises, then the programmed byte.
    always @(posedge clk) en_age <= lcd_en ? en_age + 1 : 0;
    assign lcd_data = (en_age >= 8) ? model_val : 8'hFF;

    typedef struct {
        logic       rs;
        logic [7:0] val;
        logic [7:0] exp_data;
        logic       exp_busy;
        logic [6:0] exp_ac;
    } vec_t;

    vec_t tab[6];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_rdy(input string name);
        int w = 0;
        while (!rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdy) chk({name, ".rdy_timeout"}, 0, 1);
    endtask

    // Issues one read at a negedge and samples j=0..25 negedges after the accept edge.
    task automatic run_read(input logic r, input logic [7:0] v, input string name);
        int en_first = -1, en_cnt = 0, vld_at = -1, vld_cnt = 0, pins_ok = 1;
        model_val = v;
        rs = r;
        vld = 1'b1;
        wait_rdy(name);
        @(posedge clk);
        #1 vld = 1'b0;
        for (int j = 0; j <= 25; j++) begin
            @(negedge clk);
            if (lcd_en) begin
                en_cnt++;
                if (en_first < 0) en_first = j;
            end
            if (rd_vld) begin
                vld_cnt++;
                vld_at = j;
            end
            if (j <= 24 && !(lcd_rw && bus_rd && lcd_rs == r && !rdy)) pins_ok = 0;
        end
        chk({name, ".en_first"}, en_first, 2);
        chk({name, ".en_width"}, en_cnt, 12);
        chk({name, ".vld_at"}, vld_at, 25);
        chk({name, ".vld_cnt"}, vld_cnt, 1);
        chk({name, ".pins"}, pins_ok, 1);
        chk({name, ".end_bus"}, {rdy, lcd_rw, bus_rd, lcd_rs}, 4'b1000);
    endtask

    initial begin
        int en_seen;
        int vcnt;
        rst_n = 1'b0;
        vld = 1'b0;
        rs = 1'b0;
        model_val = 8'h00;
`ifdef LCD_RD_BUSY_POLL_EN
        poll = 1'b0;
`endif
        tab[0] = '{1'b0, 8'h85, 8'h85, 1'b1, 7'h05};
        tab[1] = '{1'b1, 8'h41, 8'h41, 1'b1, 7'h05};
        tab[2] = '{1'b0, 8'h3A, 8'h3A, 1'b0, 7'h3A};
        tab[3] = '{1'b1, 8'h00, 8'h00, 1'b0, 7'h3A};
        tab[4] = '{1'b0, 8'hC0, 8'hC0, 1'b1, 7'h40};
        tab[5] = '{1'b0, 8'h7F, 8'h7F, 1'b0, 7'h7F};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lcd_en) en_seen++;
        end
        chk("idle.en_seen", en_seen, 0);
        chk("idle.ctrl", {rdy, rd_vld, bus_rd, lcd_rw, lcd_rs, lcd_en}, 6'b100000);
        chk("idle.rd_data", rd_data, 0);
        chk("idle.busy_ac", {busy, ac}, 0);

        // Back-to-back: each read is issued right at the previous o_rd_vld cycle.
        for (int i = 0; i < 6; i++) begin
            run_read(tab[i].rs, tab[i].val, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.rd_data", i), rd_data, tab[i].exp_data);
            chk($sformatf("vec%0d.busy", i), busy, tab[i].exp_busy);
            chk($sformatf("vec%0d.ac", i), ac, tab[i].exp_ac);
        end

        @(negedge clk);
        chk("hold.rd_data", rd_data, 8'h7F);
        chk("hold.vld_low", rd_vld, 0);

        model_val = 8'h85;
        rs = 1'b0;
        vld = 1'b1;
        wait_rdy("rst");
        @(posedge clk);
        #1 vld = 1'b0;
        for (int j = 0; j <= 6; j++) @(negedge clk);
        chk("rst.en_before", lcd_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst.pins", {lcd_en, lcd_rw, bus_rd, rdy, rd_vld}, 5'b00010);
        chk("rst.result", {rd_data, busy, ac}, 0);
        rst_n = 1'b1;
        vcnt = 0;
        en_seen = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (rd_vld) vcnt++;
            if (lcd_en) en_seen++;
        end
        chk("rst.no_vld", vcnt, 0);
        chk("rst.no_en", en_seen, 0);

        run_read(1'b1, 8'h5A, "post_rst");
        chk("post_rst.rd_data", rd_data, 8'h5A);
        chk("post_rst.busy_ac", {busy, ac}, 0);

`ifdef LCD_RD_BUSY_POLL_EN
        begin
            logic [7:0] pv[4];
            int rises = 0, idx = 0, vat = -1;
            logic prev_en = 1'b0;
            pv[0] = 8'h80;
            pv[1] = 8'h80;
            pv[2] = 8'h80;
            pv[3] = 8'h10;
            vcnt = 0;
            model_val = pv[0];
            rs = 1'b1;
            poll = 1'b1;
            vld = 1'b1;
            wait_rdy("poll");
            @(posedge clk);
            #1 vld = 1'b0;
            poll = 1'b0;
            for (int j = 0; j <= 110; j++) begin
                @(negedge clk);
                if (lcd_en && !prev_en) rises++;
                if (!lcd_en && prev_en) begin
                    idx++;
                    if (idx < 4) model_val = pv[idx];
                end
                prev_en = lcd_en;
                if (rd_vld) begin
                    vcnt++;
                    vat = j;
                end
            end
            chk("poll.en_pulses", rises, 4);
            chk("poll.vld_cnt", vcnt, 1);
            chk("poll.vld_at", vat, 100);
            chk("poll.ac", ac, 7'h10);
            chk("poll.busy", busy, 0);
            chk("poll.timeout", timeout, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
